// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifts.
// Define MULTICYCLE_ALU_MUL_EN to decode acode 111 as a shift-add unsigned multiply (otherwise pass A).
module multicycle_alu #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic                    carry_in,
   input  logic                    is_shift,
   input  logic [1:0]              scode,
   input  logic [2:0]              acode,
   output logic signed [WIDTH-1:0] R,
   output logic                    zero,
   output logic                    carry_out,
   output logic                    busy,
   output logic                    done
);

   localparam int CNT_W = ($clog2(WIDTH + 1) > SHAMT_W) ? $clog2(WIDTH + 1) : SHAMT_W;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_load;
   logic [WIDTH-1:0]   r_q;
   logic               zero_q;
   logic               carry_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   opb_q;
   logic               cin_q;
   logic               shift_q;
   logic [1:0]         scode_q;
   logic [2:0]         acode_q;

   logic [WIDTH-1:0]   addend;
   logic               cterm;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]   fin_r;
   logic               fin_c;

`ifdef MULTICYCLE_ALU_MUL_EN
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   mhi_q;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH:0]     msum;
`endif

   // Number of RUN cycles for the requested operation (at least one).
   always_comb begin
      cnt_load = CNT_W'(1);
      if (is_shift) begin
         if (B[SHAMT_W-1:0] != '0) cnt_load = CNT_W'(B[SHAMT_W-1:0]);
      end
`ifdef MULTICYCLE_ALU_MUL_EN
      else if (acode == 3'b111) begin
         cnt_load = CNT_W'(WIDTH);
      end
`endif
   end

   // Subtract variants invert B; carry term is 1 for sub, carry_in for addc/subc.
   always_comb begin
      addend   = acode_q[1] ? ~opb_q : opb_q;
      cterm    = acode_q[0] ? cin_q : acode_q[1];
      sum      = {1'b0, acc_q} + {1'b0, addend} + {{WIDTH{1'b0}}, cterm};
      step_acc = acc_q;
      fin_r    = acc_q;
      fin_c    = carry_q;
`ifdef MULTICYCLE_ALU_MUL_EN
      msum     = {1'b0, mhi_q} + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
      step_hi  = mhi_q;
`endif
      if (shift_q) begin
         if (opb_q[SHAMT_W-1:0] != '0) begin
            case (scode_q)
               2'b00: begin
                  step_acc = {acc_q[WIDTH-2:0], 1'b0};
                  fin_c    = acc_q[WIDTH-1];
               end
               2'b01: begin
                  step_acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                  fin_c    = acc_q[0];
               end
               2'b10:   step_acc = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
               default: step_acc = {acc_q[0], acc_q[WIDTH-1:1]};
            endcase
         end
         fin_r = step_acc;
      end else begin
         case (acode_q)
            3'b000, 3'b001, 3'b010, 3'b011: begin
               fin_r = sum[WIDTH-1:0];
               fin_c = sum[WIDTH];
            end
            3'b100:  fin_r = acc_q & opb_q;
            3'b101:  fin_r = acc_q | opb_q;
            3'b110:  fin_r = acc_q ^ opb_q;
            default: begin
`ifdef MULTICYCLE_ALU_MUL_EN
               // {mhi_q, acc_q} is the product register; multiplier bits drain from acc_q's LSB.
               step_hi  = msum[WIDTH:1];
               step_acc = {msum[0], acc_q[WIDTH-1:1]};
               fin_r    = step_acc;
               fin_c    = |step_hi;
`else
               fin_r    = acc_q;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && start) begin
         acc_q   <= A;
         opb_q   <= B;
         cin_q   <= carry_in;
         shift_q <= is_shift;
         scode_q <= scode;
         acode_q <= acode;
`ifdef MULTICYCLE_ALU_MUL_EN
         opa_q   <= A;
         mhi_q   <= '0;
         if (!is_shift && acode == 3'b111) acc_q <= B;
`endif
      end else if (state_q == RUN) begin
         acc_q <= step_acc;
`ifdef MULTICYCLE_ALU_MUL_EN
         mhi_q <= step_hi;
`endif
      end
   end

   // Results are written only on the final RUN cycle, so an abort leaves no partial value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= RUN;
                  cnt_q   <= cnt_load;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
                  r_q     <= fin_r;
                  zero_q  <= (fin_r == '0);
                  carry_q <= fin_c;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign R         = r_q;
   assign zero      = zero_q;
   assign carry_out = carry_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=8.
module tb_multicycle_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       carry_in;
   logic       is_shift;
   logic [1:0] scode;
   logic [2:0] acode;
   logic [7:0] R;
   logic       zero;
   logic       carry_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int lat;
   int pulses;
   logic [7:0] rr;

   multicycle_alu #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .carry_in(carry_in),
      .is_shift(is_shift), .scode(scode), .acode(acode), .R(R), .zero(zero),
      .carry_out(carry_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op; inputs are scrambled after the accepting edge. lat = negedges until done.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sh, input logic [1:0] sc, input logic [2:0] ac,
                        output int latency);
      @(negedge clk);
      A = a; B = b; carry_in = cin; is_shift = sh; scode = sc; acode = ac; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = ~a; B = ~b; carry_in = ~cin; is_shift = ~sh; scode = ~sc; acode = ~ac;
      latency = 1;
      while (!done && latency < 40) begin
         @(negedge clk);
         latency++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; carry_in = 1'b0;
      is_shift = 1'b0; scode = '0; acode = '0;
      repeat (2) @(negedge clk);
      check("rst_R", R, 8'h00);
      check("rst_zero", zero, 1'b1);
      check("rst_carry", carry_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b0;

      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 2'b00, 3'b000, lat);
      check("add_lat", lat, 2);
      check("add_R", R, 8'h00);
      check("add_zero", zero, 1'b1);
      check("add_carry", carry_out, 1'b1);
      check("add_busy", busy, 1'b1);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);

      do_op(8'h01, 8'h01, 1'b0, 1'b1, 2'b11, 3'b000, lat);
      check("ror_lat", lat, 2);
      check("ror_R", R, 8'h80);
      check("ror_carry_kept", carry_out, 1'b1);

      do_op(8'h80, 8'h03, 1'b0, 1'b1, 2'b01, 3'b000, lat);
      check("sar_lat", lat, 4);
      check("sar_R", R, 8'hF0);
      check("sar_carry", carry_out, 1'b0);

      do_op(8'h05, 8'h05, 1'b0, 1'b0, 2'b00, 3'b011, lat);
      check("subc_R", R, 8'hFF);
      check("subc_carry", carry_out, 1'b0);
      check("subc_zero", zero, 1'b0);

      do_op(8'h7F, 8'h00, 1'b1, 1'b0, 2'b00, 3'b001, lat);
      check("addc_R", R, 8'h80);
      check("addc_carry", carry_out, 1'b0);

      do_op(8'h05, 8'h03, 1'b0, 1'b0, 2'b00, 3'b010, lat);
      check("sub_R", R, 8'h02);
      check("sub_carry", carry_out, 1'b1);

      do_op(8'hF0, 8'h3C, 1'b0, 1'b0, 2'b00, 3'b100, lat);
      check("and_R", R, 8'h30);
      check("and_carry_kept", carry_out, 1'b1);
      do_op(8'hA0, 8'h05, 1'b0, 1'b0, 2'b00, 3'b101, lat);
      check("or_R", R, 8'hA5);
      do_op(8'hFF, 8'h0F, 1'b0, 1'b0, 2'b00, 3'b110, lat);
      check("xor_R", R, 8'hF0);
      check("xor_lat", lat, 2);

      do_op(8'h5A, 8'h00, 1'b0, 1'b1, 2'b00, 3'b000, lat);
      check("shl0_lat", lat, 2);
      check("shl0_R", R, 8'h5A);
      check("shl0_carry_kept", carry_out, 1'b1);

      do_op(8'h01, 8'h09, 1'b0, 1'b1, 2'b00, 3'b000, lat);
      check("shl_mod_lat", lat, 2);
      check("shl_mod_R", R, 8'h02);
      check("shl_mod_carry", carry_out, 1'b0);

      do_op(8'h81, 8'h02, 1'b1, 1'b1, 2'b10, 3'b000, lat);
      check("rol_lat", lat, 3);
      check("rol_R", R, 8'h06);
      check("rol_carry_kept", carry_out, 1'b0);

`ifdef MULTICYCLE_ALU_MUL_EN
      do_op(8'h10, 8'h10, 1'b0, 1'b0, 2'b00, 3'b111, lat);
      check("mul_lat", lat, 9);
      check("mul_R", R, 8'h00);
      check("mul_carry", carry_out, 1'b1);
      check("mul_zero", zero, 1'b1);
`else
      do_op(8'h33, 8'h10, 1'b1, 1'b0, 2'b00, 3'b111, lat);
      check("pass_lat", lat, 2);
      check("pass_R", R, 8'h33);
      check("pass_carry_kept", carry_out, 1'b0);
`endif

      // start held high through the op while A changes after capture
      @(negedge clk);
      A = 8'h10; B = 8'h01; carry_in = 1'b0; is_shift = 1'b0; acode = 3'b000; start = 1'b1;
      pulses = 0;
      rr = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) A = 8'h20;
         if (done) begin
            pulses++;
            rr = R;
            start = 1'b0;
         end
      end
      check("hold_pulses", pulses, 1);
      check("hold_R", rr, 8'h11);

      do_op(8'h81, 8'h01, 1'b0, 1'b1, 2'b00, 3'b000, lat);
      check("shl1_R", R, 8'h02);
      check("shl1_carry", carry_out, 1'b1);

      // reset in the middle of a shl by 7
      @(negedge clk);
      A = 8'h01; B = 8'h07; is_shift = 1'b1; scode = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_R", R, 8'h00);
      check("abort_zero", zero, 1'b1);
      check("abort_carry", carry_out, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort_no_done", pulses, 0);
      check("abort_R_held", R, 8'h00);

      do_op(8'h01, 8'h02, 1'b0, 1'b0, 2'b00, 3'b000, lat);
      check("post_rst_lat", lat, 2);
      check("post_rst_R", R, 8'h03);
      check("post_rst_zero", zero, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data path width in bits (legal 4..32).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), width of the used shift-amount field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  operation request, sampled on a rising clk edge while busy=0.
REQ-006 SHALL have port A  input  WIDTH  signed operand A.
REQ-007 SHALL have port B  input  WIDTH  signed operand B; for shifts, B[SHAMT_W-1:0] is the shift amount.
REQ-008 SHALL have port carry_in  input  1  carry/borrow input for the addc and subc operations.
REQ-009 SHALL have port is_shift  input  1  1 selects the shift unit, 0 selects the arithmetic/logic unit.
REQ-010 SHALL have port scode  input  2  shift op: 00 shl, 01 sar, 10 rol, 11 ror.
REQ-011 SHALL have port acode  input  3  ALU op: 000 add, 001 addc, 010 sub, 011 subc, 100 and, 101 or, 110 xor, 111 see REQ-034.
REQ-012 SHALL have port R  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  registered, high when R == 0.
REQ-014 SHALL have port carry_out  output  1  registered carry flag.
REQ-015 SHALL have port busy  output  1  high while an operation is in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse marking R, zero and carry_out updated.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE; transitions are IDLE->RUN on start, RUN->DONE when the count reaches zero, and DONE->IDLE unconditionally.
REQ-018 SHALL capture A, B, carry_in, is_shift, scode and acode into internal registers on the start edge; later input changes SHALL NOT affect the operation.
REQ-019 SHALL drive busy high in RUN and DONE, and SHALL ignore start while busy=1.
REQ-020 SHALL assert done for exactly one cycle, in the DONE state, with R, zero and carry_out valid in that same cycle.
REQ-021 SHALL hold R, zero and carry_out stable from one done pulse until the next.
REQ-022 SHALL complete ALU ops (acode 000-110) in 1 RUN cycle, so done is asserted 2 cycles after the start edge.
REQ-023 SHALL compute add and addc as A+B and A+B+carry_in in WIDTH+1 bits; R = low WIDTH bits, carry_out = bit WIDTH.
REQ-024 SHALL compute sub and subc as A+~B+1 and A+~B+carry_in in WIDTH+1 bits; carry_out = bit WIDTH (1 = no borrow).
REQ-025 SHALL compute and, or and xor bitwise, and SHALL leave carry_out unchanged for these ops.
REQ-026 SHALL perform shifts iteratively, one bit position per RUN cycle, taking n = B[SHAMT_W-1:0] RUN cycles (minimum 1).
REQ-027 SHALL, for a shift with n=0, return R=A with carry_out unchanged, completing with 1 RUN cycle.
REQ-028 SHALL implement shl as logical left with zero fill; carry_out = last bit shifted out of the MSB.
REQ-029 SHALL implement sar as arithmetic right with sign fill; carry_out = last bit shifted out of the LSB.
REQ-030 SHALL implement rol and ror as rotations, and SHALL leave carry_out unchanged for them.
REQ-031 SHALL ignore bits of B above SHAMT_W-1 for shifts (shift amount is taken modulo 2^SHAMT_W).

Reset
REQ-032 SHALL, on rst high and regardless of clk, force state=IDLE, R=0, zero=1, carry_out=0, busy=0 and done=0.
REQ-033 SHALL abort any in-progress operation on reset, with no done pulse and no partial result on R.

Configuration
REQ-034 SHALL, with macro MULTICYCLE_ALU_MUL_EN defined, decode acode 111 as unsigned multiply: R = low WIDTH bits of A*B, computed by shift-add over WIDTH RUN cycles (done WIDTH+1 cycles after start); carry_out = 1 if the high half is nonzero.
REQ-035 SHALL, without MULTICYCLE_ALU_MUL_EN, decode acode 111 as pass (R=A, carry_out unchanged, 1 RUN cycle) and contain no multiplier logic.

Verification
REQ-036 SHALL pass: WIDTH=8, add A=0xFF B=0x01 -> done 2 cycles after start, R=0x00, zero=1, carry_out=1.
REQ-037 SHALL pass: subc A=0x05 B=0x05 carry_in=0 -> R=0xFF, carry_out=0, zero=0.
REQ-038 SHALL pass: sar A=0x80 B=0x03 -> done 4 cycles after start, R=0xF0, carry_out=0; and ror A=0x01 B=0x01 -> R=0x80, carry_out unchanged.
REQ-039 SHALL pass: start held high while busy and A changed mid-operation -> exactly one done pulse per accepted start, result computed from the originally captured A.
REQ-040 SHALL pass: rst pulsed during a shl by 7 -> busy=0, R=0, zero=1, carry_out=0 immediately, with no done pulse.
REQ-041 SHALL pass: MUL_EN build, A=0x10 B=0x10 acode=111 -> done 9 cycles after start, R=0x00, carry_out=1, zero=1.
